// File: rtl/carry_pipe_pkg.sv
// carry_pipe_pkg
//   Shared constants and types for the split-carry adder pipeline.
//   WIDTH/SPLIT/CNT_W  : default build of carry_split_adder_pipe
//   LO_W / HI_W        : low-half and high-half adder result widths
//                        (each one bit wider than its operands to keep
//                        the carry)
//   s1_payload_t       : stage-1 register contents for the default build
//   lo_w() / hi_w()    : the same derivations for any WIDTH/SPLIT, so
//                        parameterized builds stay consistent with the
//                        defaults
package carry_pipe_pkg;

  localparam int WIDTH = 10;
  localparam int SPLIT = 5;
  localparam int CNT_W = 16;

  localparam int LO_W = SPLIT + 1;
  localparam int HI_W = WIDTH - SPLIT + 1;

  typedef struct packed {
    logic [LO_W-1:0] lo;    // lo[LO_W-1] is the carry handed to stage 2
    logic [HI_W-2:0] a_hi;
    logic [HI_W-2:0] b_hi;
  } s1_payload_t;

  function automatic int lo_w(input int split);
    return split + 1;
  endfunction

  function automatic int hi_w(input int width, input int split);
    return width - split + 1;
  endfunction

endpackage

// File: rtl/carry_pipe_stage.sv
// carry_pipe_stage
//   Generic one-deep valid/ready register slice with full throughput.
//   clk, resetn            : clock, async active-low reset
//   in_valid/in_ready/in_data    : upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake, registered payload
//   The slice reloads whenever it is empty or its content leaves this
//   cycle, so in_ready is combinational from out_ready.
module carry_pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          valid_d, valid_q;
  logic [DW-1:0] data_d,  data_q;
  logic          adv;

  always_comb begin
    adv     = !valid_q || out_ready;
    // On advance the slot takes whatever is offered (possibly nothing);
    // otherwise it holds, which keeps the payload stable under stall.
    valid_d = adv ? in_valid : valid_q;
    data_d  = (adv && in_valid) ? in_data : data_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/carry_split_adder_pipe.sv
// carry_split_adder_pipe
//   Two-stage adder with the carry chain broken at SPLIT. Stage 1 adds the
//   low SPLIT bits and registers the carry with the raw high halves; stage 2
//   finishes the high half and registers {cout, sum}.
//   clk, resetn                    : clock, async active-low reset
//   in_valid/in_ready, in_a/in_b   : operand pair handshake
//   out_valid/out_ready            : result handshake
//   out_sum/out_cout/out_msb       : (A+B) mod 2^WIDTH, carry out, sum MSB
//   cout_cnt                       : saturating count of delivered results
//                                    that carried out
module carry_split_adder_pipe
  import carry_pipe_pkg::*;
#(
  parameter int WIDTH = carry_pipe_pkg::WIDTH,
  parameter int SPLIT = carry_pipe_pkg::SPLIT,
  parameter int CNT_W = carry_pipe_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_msb,
  output logic [CNT_W-1:0] cout_cnt
);

  localparam int L_W = lo_w(SPLIT);
  localparam int H_W = hi_w(WIDTH, SPLIT);

  typedef struct packed {
    logic [L_W-1:0] lo;
    logic [H_W-2:0] a_hi;
    logic [H_W-2:0] b_hi;
  } s1_t;

  s1_t              s1_d, s1_q;
  logic             s1_valid;
  logic             adv2;
  logic [H_W-1:0]   hi;
  logic [WIDTH:0]   s2_d, s2_q;   // {cout, sum}
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Stage 1: low-half add, carry kept in the top bit of lo.
  always_comb begin
    s1_d      = '0;
    s1_d.lo   = {1'b0, in_a[SPLIT-1:0]} + {1'b0, in_b[SPLIT-1:0]};
    s1_d.a_hi = in_a[WIDTH-1:SPLIT];
    s1_d.b_hi = in_b[WIDTH-1:SPLIT];
  end

  carry_pipe_stage #(.DW($bits(s1_t))) u_s1 (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_d),
    .out_valid (s1_valid),
    .out_ready (adv2),
    .out_data  (s1_q)
  );

  // Stage 2: high-half add consuming the registered low carry. hi is one
  // bit wider than the operands so its MSB is the block carry-out.
  always_comb begin
    hi   = {1'b0, s1_q.a_hi} + {1'b0, s1_q.b_hi}
         + {{(H_W-1){1'b0}}, s1_q.lo[L_W-1]};
    s2_d = {hi, s1_q.lo[L_W-2:0]};
  end

  carry_pipe_stage #(.DW(WIDTH+1)) u_s2 (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (s1_valid),
    .in_ready  (adv2),
    .in_data   (s2_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_q)
  );

  assign out_sum  = s2_q[WIDTH-1:0];
  assign out_cout = s2_q[WIDTH];
  assign out_msb  = s2_q[WIDTH-1];

  // Counts deliveries, not stage-2 loads, so stalled results count once.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready && out_cout && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cout_cnt = cnt_q;

endmodule

// File: tb/tb_carry_split_adder_pipe.sv
module tb_carry_split_adder_pipe;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         resetn;
  logic         in_valid, out_ready;
  logic [W-1:0] in_a, in_b;
  logic         in_ready, out_valid, out_cout, out_msb;
  logic [W-1:0] out_sum;
  logic [15:0]  cout_cnt;
  logic         in_ready_s, out_valid_s, out_cout_s, out_msb_s;
  logic [W-1:0] out_sum_s;
  logic [1:0]   cout_cnt_s;

  always #5 clk = ~clk;

  carry_split_adder_pipe #(.WIDTH(W), .SPLIT(5), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_msb(out_msb),
    .cout_cnt(cout_cnt));

  carry_split_adder_pipe #(.WIDTH(W), .SPLIT(5), .CNT_W(2)) dut_sat (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_sum(out_sum_s), .out_cout(out_cout_s), .out_msb(out_msb_s),
    .cout_cnt(cout_cnt_s));

  int checks = 0, failures = 0;
  int stray = 0, cnt_model = 0;
  logic [W:0] sb[$];

  bit         acc, del, got_msb;
  logic [W:0] got, exp;

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic int sat_model();
    return (cnt_model > 3) ? 3 : cnt_model;
  endfunction

  task automatic cycle();
    #2;
    acc = in_valid && in_ready;
    del = out_valid && out_ready;
    got = {out_cout, out_sum};
    got_msb = out_msb;
    exp = 'x;
    if (del) begin
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        if (exp[W]) cnt_model++;
      end else stray++;
    end
    if (acc) sb.push_back(model(in_a, in_b));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out_cout, out_msb, out_sum} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b_%b_%b_%h want=0", out_valid, out_cout, out_msb, out_sum);
    end
    checks++;
    if (cout_cnt !== 16'd0 || cout_cnt_s !== 2'd0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d/%0d want=0", cout_cnt, cout_cnt_s);
    end
    resetn = 1'b1;
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_carry_split();
    out_ready = 1'b1; in_valid = 1'b1; in_a = 10'h1FF; in_b = 10'h001;
    cycle();
    in_valid = 1'b0; in_a = W'($urandom); in_b = W'($urandom);
    checks++;
    if (!acc || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL split_latency1 acc=%b out_valid=%b want 1/0", acc, out_valid);
    end
    cycle();
    checks++;
    if ({out_valid, out_sum, out_msb, out_cout} !== {1'b1, 10'h200, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL split_result got v=%b sum=%h msb=%b cout=%b want 1/200/1/0",
               out_valid, out_sum, out_msb, out_cout);
    end
    cycle();
    checks++;
    if (!del || got !== exp || cout_cnt !== 16'(cnt_model) || cout_cnt !== 16'd0) begin
      failures++;
      $display("FAIL split_deliver del=%b got=%h want=%h cnt=%0d want=0", del, got, exp, cout_cnt);
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1; in_valid = 1'b1; in_a = 10'h3FF; in_b = 10'h001;
    cycle();
    in_valid = 1'b0;
    cycle();
    checks++;
    if ({out_valid, out_sum, out_msb, out_cout} !== {1'b1, 10'h000, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL wrap_result got v=%b sum=%h msb=%b cout=%b want 1/000/0/1",
               out_valid, out_sum, out_msb, out_cout);
    end
    cycle();
    checks++;
    if (!del || got !== exp || cout_cnt !== 16'd1 || cout_cnt !== 16'(cnt_model)) begin
      failures++;
      $display("FAIL wrap_deliver del=%b got=%h want=%h cnt=%0d want=1", del, got, exp, cout_cnt);
    end
  endtask

  task automatic test_throughput();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = (k < 8); in_a = W'(k); in_b = W'(3 * k);
      cycle();
      if (k < 8) begin
        checks++;
        if (!acc) begin
          failures++;
          $display("FAIL thru_in_ready k=%0d got=0 want=1", k);
        end
      end
      if (k >= 2) begin
        checks++;
        if (!del || got !== exp || got !== (W+1)'(4 * (k - 2)) || got_msb !== got[W-1]) begin
          failures++;
          $display("FAIL thru_result k=%0d del=%b got=%h want=%h", k, del, got, (W+1)'(4 * (k - 2)));
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] pa [3];
    logic [W-1:0] pb [3];
    logic [W:0]   want [3];
    pa[0] = 10'h100; pb[0] = 10'h100; want[0] = 11'h200;
    pa[1] = 10'h010; pb[1] = 10'h020; want[1] = 11'h030;
    pa[2] = 10'h3FF; pb[2] = 10'h3FF; want[2] = 11'h7FE;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = pa[i]; in_b = pb[i];
      cycle();
      checks++;
      if (acc !== (i < 2)) begin
        failures++;
        $display("FAIL bp_accept i=%0d got=%b want=%b", i, acc, (i < 2));
      end
    end
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if (acc || !out_valid || out_sum !== 10'h200 || out_cout !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold i=%0d acc=%b v=%b sum=%h want 0/1/200", i, acc, out_valid, out_sum);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (i == 0) begin
        checks++;
        if (!acc) begin
          failures++;
          $display("FAIL bp_refill got=0 want=1");
        end
      end
      in_valid = 1'b0;
      checks++;
      if (!del || got !== exp || got !== want[i]) begin
        failures++;
        $display("FAIL bp_order i=%0d del=%b got=%h want=%h", i, del, got, want[i]);
      end
    end
    checks++;
    if (cout_cnt !== 16'(cnt_model) || cout_cnt !== 16'd2) begin
      failures++;
      $display("FAIL bp_cnt got=%0d want=2", cout_cnt);
    end
  endtask

  task automatic test_reset_midflight();
    int n = 0;
    out_ready = 1'b0; in_valid = 1'b1; in_a = 10'h3FF; in_b = 10'h001;
    cycle();
    in_a = 10'h3FF; in_b = 10'h3FF;
    cycle();
    in_valid = 1'b0;
    cycle();
    #1 resetn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_valid_s !== 1'b0 || cout_cnt !== 16'd0 || cout_cnt_s !== 2'd0) begin
      failures++;
      $display("FAIL rst_async v=%b/%b cnt=%0d/%0d want 0", out_valid, out_valid_s, cout_cnt, cout_cnt_s);
    end
    sb.delete();
    cnt_model = 0;
    @(negedge clk);
    resetn = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_a = 10'h005; in_b = 10'h003;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (del) begin
        n++;
        checks++;
        if (got !== exp || got !== 11'h008) begin
          failures++;
          $display("FAIL rst_result got=%h want=008", got);
        end
      end
    end
    checks++;
    if (n != 1 || stray != 0) begin
      failures++;
      $display("FAIL rst_count deliveries=%0d stray=%0d want 1/0", n, stray);
    end
  endtask

  task automatic test_saturation();
    logic [W-1:0] pa [6];
    logic [W-1:0] pb [6];
    pa[0] = 10'h3FF; pb[0] = 10'h001;
    pa[1] = 10'h200; pb[1] = 10'h200;
    pa[2] = 10'h3FF; pb[2] = 10'h3FF;
    pa[3] = 10'h201; pb[3] = 10'h3FF;
    pa[4] = 10'h300; pb[4] = 10'h100;
    pa[5] = 10'h001; pb[5] = 10'h002;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = (i < 6);
      if (i < 6) begin in_a = pa[i]; in_b = pb[i]; end
      cycle();
      if (del) begin
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL sat_result i=%0d got=%h want=%h", i, got, exp);
        end
      end
      if (i == 6) begin
        checks++;
        if (cout_cnt_s !== 2'(sat_model()) || cnt_model != 5 || cout_cnt_s !== 2'd3) begin
          failures++;
          $display("FAIL sat_cnt got=%0d want=3", cout_cnt_s);
        end
      end
    end
    in_valid = 1'b0;
    cycle();
    checks++;
    if (cout_cnt_s !== 2'd3 || cout_cnt !== 16'(cnt_model) || cout_cnt !== 16'd5) begin
      failures++;
      $display("FAIL sat_hold got=%0d/%0d want 3/5", cout_cnt_s, cout_cnt);
    end
    checks++;
    if (sb.size() != 0 || stray != 0) begin
      failures++;
      $display("FAIL scoreboard_empty left=%0d stray=%0d want 0/0", sb.size(), stray);
    end
  endtask

  initial begin
    test_reset();
    test_carry_split();
    test_wrap();
    test_throughput();
    test_backpressure();
    test_reset_midflight();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
